// File: rtl/muldiv_sequencer.sv
// Sequences multi-cycle multiply/divide ops from the EX stage: starts the
// selected unit, stalls the front of the pipeline while it runs, and holds
// the result for EX_MEM capture. Handles flush (drain), debug freeze and a
// wait timeout that sets a sticky error flag.
module muldiv_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        issue_valid,
  input  logic        is_mul,
  input  logic        is_div,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  input  logic        mem_hold,
  input  logic        dbg,
  input  logic        mul_done,
  input  logic        div_done,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  output logic        mul_start,
  output logic        div_start,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res,
  output logic [4:0]  res_rd,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_WAIT,
    DONE,
    DRAIN
  } state_t;

  localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  cnt;
  logic        pend;
  logic [31:0] pend_res;
  logic        drain_div;
  logic        err_q;
  logic [31:0] res_q;
  logic [4:0]  rd_q;

  logic        op_present;
  logic        in_wait;
  logic        tracking;
  logic        unit_div;
  logic        live_done;
  logic [31:0] live_res;
  logic        unit_done;
  logic [31:0] unit_res;
  logic        capture;
  logic        set_err;

  assign op_present = issue_valid & (is_mul | is_div);
  assign in_wait    = (state == MUL_WAIT) | (state == DIV_WAIT);
  assign tracking   = in_wait | (state == DRAIN);
  // In DRAIN the outstanding unit is remembered in drain_div.
  assign unit_div   = (state == DIV_WAIT) | ((state == DRAIN) & drain_div);
  assign live_done  = unit_div ? div_done : mul_done;
  assign live_res   = unit_div ? div_res : mul_res;
  // A done seen during dbg is replayed from pend/pend_res once dbg falls.
  assign unit_done  = pend | live_done;
  assign unit_res   = pend ? pend_res : live_res;

  // State, counter, pending-done and result registers
  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      pend_res  <= '0;
      drain_div <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
      rd_q      <= '0;
    end else if (dbg) begin
      if (tracking && live_done && !pend) begin
        pend     <= 1'b1;
        pend_res <= live_res;
      end
    end else begin
      state <= state_nxt;
      pend  <= 1'b0;
      if ((state_nxt != state) &&
          ((state_nxt == MUL_WAIT) || (state_nxt == DIV_WAIT) || (state_nxt == DRAIN)))
        cnt <= '0;
      else if (tracking)
        cnt <= cnt + 7'd1;
      if ((state == IDLE) && (state_nxt != IDLE))
        rd_q <= issue_rd;
      if (in_wait && (state_nxt == DRAIN))
        drain_div <= (state == DIV_WAIT);
      if (capture)
        res_q <= unit_res;
      if (set_err)
        err_q <= 1'b1;
    end
  end

  // Next-state decision; frozen entirely while dbg is high
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    set_err   = 1'b0;
    if (!dbg) begin
      case (state)
        IDLE: begin
          if (op_present && !flush)
            state_nxt = is_mul ? MUL_WAIT : DIV_WAIT;
        end
        MUL_WAIT, DIV_WAIT: begin
          // A done coinciding with flush means the unit is already idle,
          // so there is nothing left to drain.
          if (unit_done) begin
            state_nxt = flush ? IDLE : DONE;
            capture   = !flush;
          end else if (flush) begin
            state_nxt = DRAIN;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            set_err   = 1'b1;
          end
        end
        DONE: begin
          if (flush || !mem_hold)
            state_nxt = IDLE;
        end
        DRAIN: begin
          if (unit_done) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            set_err   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; start pulse fires on the first unfrozen wait cycle
  always_comb begin
    mul_start = !Rst && !dbg && (state == MUL_WAIT) && (cnt == '0);
    div_start = !Rst && !dbg && (state == DIV_WAIT) && (cnt == '0);
    stall     = !Rst && (in_wait ||
                         ((state == IDLE) && op_present && !flush) ||
                         ((state == DRAIN) && op_present));
    res_valid = (state == DONE);
    res       = res_q;
    res_rd    = rd_q;
    busy      = (state != IDLE);
    err       = err_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_muldiv_sequencer;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        is_mul = 1'b0;
  logic        is_div = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;
  logic        mem_hold = 1'b0;
  logic        dbg = 1'b0;
  logic        mul_done = 1'b0;
  logic        div_done = 1'b0;
  logic [31:0] mul_res = '0;
  logic [31:0] div_res = '0;
  logic        mul_start, div_start, stall, res_valid, busy, err;
  logic [31:0] res;
  logic [4:0]  res_rd;

  muldiv_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .Rst(Rst), .issue_valid(issue_valid), .is_mul(is_mul),
    .is_div(is_div), .issue_rd(issue_rd), .flush(flush), .mem_hold(mem_hold),
    .dbg(dbg), .mul_done(mul_done), .div_done(div_done), .mul_res(mul_res),
    .div_res(div_res), .mul_start(mul_start), .div_start(div_start),
    .stall(stall), .res_valid(res_valid), .res(res), .res_rd(res_rd),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  // Model: which unit an op is waiting on (0 none, 1 mul, 2 div), which unit
  // is being drained, whether a result is being offered, and elapsed wait cycles.
  int          m_unit = 0;
  int          m_drain = 0;
  int          m_elapsed = 0;
  bit          m_have = 1'b0;
  bit          m_err = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pval = '0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit got;
    int u;
    logic [31:0] v;
    u = (m_unit != 0) ? m_unit : m_drain;
    if (Rst) begin
      m_unit = 0; m_drain = 0; m_elapsed = 0; m_have = 0; m_err = 0;
      m_pend = 0; m_pval = '0; m_res = '0; m_rd = '0;
    end else if (dbg) begin
      if (u != 0 && !m_pend && ((u == 1) ? mul_done : div_done)) begin
        m_pend = 1;
        m_pval = (u == 1) ? mul_res : div_res;
      end
    end else begin
      got = m_pend || (u == 1 && mul_done) || (u == 2 && div_done);
      v = m_pend ? m_pval : ((u == 1) ? mul_res : div_res);
      m_pend = 0;
      if (m_have) begin
        if (flush || !mem_hold) m_have = 0;
      end else if (u != 0) begin
        if (got) begin
          if (m_unit != 0 && !flush) begin m_have = 1; m_res = v; end
          m_unit = 0; m_drain = 0;
        end else if (m_unit != 0 && flush) begin
          m_drain = m_unit; m_unit = 0; m_elapsed = 0;
        end else if (m_elapsed == int'(TO) - 1) begin
          m_err = 1; m_unit = 0; m_drain = 0;
        end else begin
          m_elapsed++;
        end
      end else if (issue_valid && (is_mul || is_div) && !flush) begin
        m_unit = is_mul ? 1 : 2;
        m_rd = issue_rd;
        m_elapsed = 0;
      end
    end
  end

  // Compare all outputs with the model once per cycle, mid-cycle
  always @(negedge clk) begin : compare
    bit idle, opp;
    if (model_on) begin
      idle = (m_unit == 0) && (m_drain == 0) && !m_have;
      opp  = issue_valid && (is_mul || is_div);
      cmp("busy", busy, !idle);
      cmp("stall", stall, !Rst && ((m_unit != 0) || (idle && opp && !flush) || ((m_drain != 0) && opp)));
      cmp("mul_start", mul_start, !Rst && !dbg && m_unit == 1 && m_elapsed == 0);
      cmp("div_start", div_start, !Rst && !dbg && m_unit == 2 && m_elapsed == 0);
      cmp("res_valid", res_valid, m_have);
      cmp("res", res, m_res);
      cmp("res_rd", res_rd, m_rd);
      cmp("err", err, m_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input bit mul, input logic [4:0] rd);
    issue_valid = 1; is_mul = mul; is_div = !mul; issue_rd = rd;
    mid();
    cmp("issue stall", stall, 1);
    cyc();
    issue_valid = 0; is_mul = 0; is_div = 0;
  endtask

  initial begin
    int dp;
    Rst = 1;
    cyc(); cyc();
    model_on = 1;
    mid();
    cmp("reset busy", busy, 0);
    cmp("reset stall", stall, 0);
    cmp("reset err", err, 0);
    cmp("reset res_valid", res_valid, 0);
    cyc();
    Rst = 0;

    // MUL rd=5, done three cycles after the start pulse
    issue(1'b1, 5'd5);
    mid(); cmp("mul start pulse", mul_start, 1); cmp("mul wait stall", stall, 1);
    cyc(); mid(); cmp("mul start once", mul_start, 0); cmp("mul wait stall2", stall, 1);
    cyc(); mid(); cmp("mul wait stall3", stall, 1);
    cyc(); mul_done = 1; mul_res = 32'h0000_0C00;
    cyc(); mul_done = 0; mul_res = '0;
    mid(); cmp("mul res_valid", res_valid, 1); cmp("mul res", res, 32'h0000_0C00);
    cmp("mul res_rd", res_rd, 5); cmp("mul done stall", stall, 0);
    cyc(); mid(); cmp("mul back idle", busy, 0);

    // DIV, done 33 cycles after start, mem_hold for two DONE cycles
    cyc();
    issue(1'b0, 5'd9);
    mid(); cmp("div start pulse", div_start, 1);
    repeat (33) cyc();
    div_done = 1; div_res = 32'hDEAD_BEEF; mem_hold = 1;
    cyc(); div_done = 0; div_res = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_hold = 0;
      mid(); cmp("div hold valid", res_valid, 1); cmp("div hold res", res, 32'hDEAD_BEEF);
      cmp("div hold rd", res_rd, 9);
      cyc();
    end
    mid(); cmp("div back idle", busy, 0);

    // DIV flushed on wait cycle 4, MUL follows through the drain
    cyc();
    issue(1'b0, 5'd3);
    cyc(); cyc(); cyc(); flush = 1;
    cyc(); flush = 0; issue_valid = 1; is_mul = 1; issue_rd = 5'd7;
    mid(); cmp("drain stall", stall, 1); cmp("drain no valid", res_valid, 0);
    cyc(); cyc(); div_done = 1; div_res = 32'h1111_1111;
    cyc(); div_done = 0;
    mid(); cmp("post drain stall", stall, 1); cmp("post drain no start", mul_start, 0);
    cyc(); issue_valid = 0; is_mul = 0; mul_done = 1; mul_res = 32'h77;
    mid(); cmp("post drain start", mul_start, 1);
    cyc(); mul_done = 0;
    mid(); cmp("post drain res", res, 32'h77); cmp("post drain rd", res_rd, 7);
    cmp("drained res_valid", res_valid, 1);
    cyc();

    // DIV with no done: timeout, sticky err until reset
    issue(1'b0, 5'd1);
    repeat (int'(TO) - 1) cyc();
    mid(); cmp("pre timeout busy", busy, 1); cmp("pre timeout err", err, 0);
    cyc();
    mid(); cmp("timeout busy", busy, 0); cmp("timeout err", err, 1); cmp("timeout stall", stall, 0);
    repeat (5) cyc();
    mid(); cmp("err sticky", err, 1);
    cyc(); Rst = 1;
    cyc(); Rst = 0;
    mid(); cmp("err cleared", err, 0);

    // Done arriving under dbg is replayed after dbg falls
    cyc();
    issue(1'b1, 5'd2);
    cyc(); dbg = 1; mul_done = 1; mul_res = 32'h1234;
    cyc(); mul_done = 0; mul_res = '0;
    mid(); cmp("dbg frozen busy", busy, 1); cmp("dbg no valid", res_valid, 0);
    cyc(); cyc(); dbg = 0;
    mid(); cmp("dbg release no valid", res_valid, 0);
    cyc();
    mid(); cmp("dbg replay valid", res_valid, 1); cmp("dbg replay res", res, 32'h1234);
    cyc();

    // Reset in DIV_WAIT, later done ignored
    issue(1'b0, 5'd4);
    cyc(); Rst = 1;
    cyc(); Rst = 0;
    mid(); cmp("rst mid busy", busy, 0); cmp("rst mid res", res, 0); cmp("rst mid rd", res_rd, 0);
    cyc(); div_done = 1; div_res = 32'hFFFF;
    cyc(); div_done = 0;
    mid(); cmp("late done busy", busy, 0); cmp("late done valid", res_valid, 0);

    // Randomized traffic, alternating frequent and rare unit completions
    cyc(); Rst = 1; cyc();
    for (int blk = 0; blk < 8; blk++) begin
      dp = (blk % 2 == 1) ? 60 : 4;
      for (int i = 0; i < 500; i++) begin
        cyc();
        Rst = ($urandom_range(0, 299) == 0);
        issue_valid = $urandom_range(0, 1) == 1;
        is_mul = $urandom_range(0, 1) == 1;
        is_div = $urandom_range(0, 1) == 1;
        issue_rd = 5'($urandom);
        flush = ($urandom_range(0, 9) == 0);
        mem_hold = ($urandom_range(0, 2) == 0);
        dbg = ($urandom_range(0, 9) == 0);
        mul_done = ($urandom_range(0, dp) == 0);
        div_done = ($urandom_range(0, dp) == 0);
        mul_res = $urandom;
        div_res = $urandom;
      end
    end
    mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
